// File: rtl/counter_pkg.sv
// Shared constants for the multi-digit counter: digit width, per-mode digit maxima
// and the direction encoding used on the s input.
package counter_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] HEX_MAX = 4'hF;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'h9;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic logic [DIGIT_W-1:0] digit_max(input logic bcd);
    return bcd ? BCD_MAX : HEX_MAX;
  endfunction

endpackage

// File: rtl/digit_cell.sv
// One counter digit: computes the next digit value and the carry/borrow that
// steps the next-higher digit. Purely combinational so the chain settles in one cycle.
module digit_cell
  import counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] cur,
  input  logic               step,
  input  logic               dir,
  input  logic [DIGIT_W-1:0] max,
  output logic [DIGIT_W-1:0] nxt,
  output logic               cout
);

  always_comb begin
    nxt  = cur;
    cout = 1'b0;
    if (step) begin
      if (dir == DIR_UP) begin
        // Out-of-range BCD codes (10..15) roll over like MAX, so the digit self-corrects.
        if (cur >= max) begin
          nxt  = '0;
          cout = 1'b1;
        end else begin
          nxt = cur + 4'd1;
        end
      end else begin
        if (cur == '0) begin
          nxt  = max;
          cout = 1'b1;
        end else if (cur > max) begin
          nxt = max;
        end else begin
          nxt = cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_digit_counter.sv
// Multi-digit BCD/hex up/down counter stepped on the rising edge of tick.
// Optional parallel load is built when COUNTER_LOAD_EN is defined.
module multi_digit_counter
  import counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          BCD    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      en,
  input  logic                      s,
`ifdef COUNTER_LOAD_EN
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
`endif
  output logic [DIGIT_W*DIGITS-1:0] n,
  output logic                      wrap,
  output logic                      zero
);

  localparam logic [DIGIT_W-1:0] MAX = digit_max(BCD);

  logic                      tick_q, tick_d;
  logic [DIGIT_W*DIGITS-1:0] n_q, n_d;
  logic                      wrap_q, wrap_d;
  logic                      cnt_event;
  logic [DIGITS:0]           step_c;
  logic [DIGIT_W*DIGITS-1:0] n_step;

  assign cnt_event = tick & ~tick_q & en;
  assign step_c[0] = cnt_event;

  // Ripple chain: digit gi steps only when every lower digit carried/borrowed.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      digit_cell u_cell (
        .cur  (n_q[gi*DIGIT_W +: DIGIT_W]),
        .step (step_c[gi]),
        .dir  (s),
        .max  (MAX),
        .nxt  (n_step[gi*DIGIT_W +: DIGIT_W]),
        .cout (step_c[gi+1])
      );
    end
  endgenerate

  always_comb begin
    tick_d = tick;
    n_d    = n_q;
    wrap_d = 1'b0;
`ifdef COUNTER_LOAD_EN
    if (load) begin
      n_d = load_val;
    end else
`endif
    if (cnt_event) begin
      n_d    = n_step;
      wrap_d = step_c[DIGITS];
    end
  end

  // tick_q resets high so a tick already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b1;
      n_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      n_q    <= n_d;
      wrap_q <= wrap_d;
    end
  end

  assign n    = n_q;
  assign wrap = wrap_q;
  assign zero = (n_q == '0);

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench for multi_digit_counter: a BCD and a hex instance share clock,
// reset, enable and direction; load checks are built with COUNTER_LOAD_EN.
module tb_multi_digit_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        s = 1'b0;
  logic        tick_b = 1'b1;
  logic        tick_h = 1'b0;
  logic [15:0] n_b, n_h;
  logic        wrap_b, wrap_h, zero_b, zero_h;
`ifdef COUNTER_LOAD_EN
  logic        load_b = 1'b0;
  logic [15:0] load_val_b = '0;
  logic        load_h = 1'b0;
  logic [15:0] load_val_h = '0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multi_digit_counter #(.DIGITS(4), .BCD(1'b1)) u_bcd (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick_b),
    .en       (en),
    .s        (s),
`ifdef COUNTER_LOAD_EN
    .load     (load_b),
    .load_val (load_val_b),
`endif
    .n        (n_b),
    .wrap     (wrap_b),
    .zero     (zero_b)
  );

  multi_digit_counter #(.DIGITS(4), .BCD(1'b0)) u_hex (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick_h),
    .en       (en),
    .s        (s),
`ifdef COUNTER_LOAD_EN
    .load     (load_h),
    .load_val (load_val_h),
`endif
    .n        (n_h),
    .wrap     (wrap_h),
    .zero     (zero_h)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Drop tick for a full cycle, raise it, and sample just after the counting edge.
  task automatic step_b();
    @(negedge clk) tick_b = 1'b0;
    @(negedge clk) tick_b = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic step_h();
    @(negedge clk) tick_h = 1'b0;
    @(negedge clk) tick_h = 1'b1;
    @(posedge clk) #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_n", n_b, 32'h0);
    check("rst_wrap", wrap_b, 32'h0);
    check("rst_zero", zero_b, 32'h1);

    // tick already high when reset releases: no event
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_evt_at_release", n_b, 32'h0);

    for (int i = 0; i < 9; i++) step_b();
    check("up_to_0009", n_b, 32'h0009);
    step_b();
    check("up_0010", n_b, 32'h0010);
    check("up_0010_wrap", wrap_b, 32'h0);

    step_b();
    check("hold_first", n_b, 32'h0011);
    repeat (100) @(posedge clk);
    #1;
    check("hold_100", n_b, 32'h0011);

    @(negedge clk) en = 1'b0;
    step_b();
    check("en0_rise", n_b, 32'h0011);
    @(negedge clk) en = 1'b1;

    @(negedge clk) s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("dir_change_quiet", n_b, 32'h0011);
    step_b();
    check("dn_0010", n_b, 32'h0010);
    step_b();
    check("dn_0009", n_b, 32'h0009);
    for (int i = 0; i < 9; i++) step_b();
    check("dn_0000", n_b, 32'h0000);
    check("dn_0000_zero", zero_b, 32'h1);
    step_b();
    check("dn_wrap_9999", n_b, 32'h9999);
    check("dn_wrap_pulse", wrap_b, 32'h1);
    check("dn_wrap_nz", zero_b, 32'h0);
    @(posedge clk) #1;
    check("dn_wrap_one_cycle", wrap_b, 32'h0);

    @(negedge clk) s = 1'b0;
    step_b();
    check("up_wrap_0000", n_b, 32'h0000);
    check("up_wrap_pulse", wrap_b, 32'h1);
    check("up_wrap_zero", zero_b, 32'h1);
    @(posedge clk) #1;
    check("up_wrap_one_cycle", wrap_b, 32'h0);

    @(negedge clk) s = 1'b1;
    step_h();
    check("hex_ffff", n_h, 32'hFFFF);
    check("hex_ffff_wrap", wrap_h, 32'h1);
    step_h();
    check("hex_fffe", n_h, 32'hFFFE);
    check("hex_fffe_wrap", wrap_h, 32'h0);

    // reset coincident with a tick rising edge
    @(negedge clk) s = 1'b0;
    step_b();
    check("pre_rst_0001", n_b, 32'h0001);
    @(negedge clk) tick_b = 1'b0;
    @(negedge clk) begin
      tick_b = 1'b1;
      rst = 1'b1;
    end
    @(posedge clk) #1;
    check("rst_mid_n", n_b, 32'h0);
    check("rst_mid_wrap", wrap_b, 32'h0);
    @(negedge clk) rst = 1'b0;

`ifdef COUNTER_LOAD_EN
    @(negedge clk) tick_b = 1'b0;
    @(negedge clk) begin
      tick_b = 1'b1;
      load_b = 1'b1;
      load_val_b = 16'h1234;
    end
    @(posedge clk) #1;
    check("load_1234", n_b, 32'h1234);
    check("load_wrap", wrap_b, 32'h0);
    @(negedge clk) begin
      rst = 1'b1;
      load_val_b = 16'h5678;
    end
    @(posedge clk) #1;
    check("rst_over_load", n_b, 32'h0);
    @(negedge clk) begin
      rst = 1'b0;
      load_val_b = 16'h000C;
    end
    @(posedge clk) #1;
    check("load_000c", n_b, 32'h000C);
    @(negedge clk) load_b = 1'b0;
    step_b();
    check("bcd_self_correct", n_b, 32'h0010);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
